// File: rtl/qar_regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, ALU/load write ports,
// same-cycle bypass, load-use busy scoreboard and a post-reset clear sequencer.
module qar_regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // state_q is the single observation point for the clear/run sequencer.
    state_t            state_q, state_d;
    logic [AW-1:0]     clr_q, clr_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]   regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            clr_q   <= AW'(1);
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_q == AW'(NREGS - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    clr_d = clr_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign ready = (state_q == ST_RUN);

    // Handshake: iss_valid has no ready counterpart; a valid issue is accepted on every
    // rising edge where ready=1 and dropped while ready=0. Set beats a same-edge WP1 clear.
    always_comb begin
        busy_d = busy_q;
        if (ready) begin
            if (we1) begin
                busy_d[waddr1] = 1'b0;
            end
            if (iss_valid) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Storage carries no reset; the clear sequencer zeroes it entry by entry.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            regs[clr_q] <= '0;
        end else begin
            if (we0 && (waddr0 != '0)) begin
                regs[waddr0] <= wdata0;
            end
            if (we1 && (waddr1 != '0)) begin
                regs[waddr1] <= wdata1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rd;
        logic            wp1_hit;
        logic            wp0_hit;

        assign addr    = raddr[k*AW +: AW];
        assign wp1_hit = we1 && (waddr1 == addr);
        assign wp0_hit = we0 && (waddr0 == addr);

        always_comb begin
            rd = '0;
            if (ready && (addr != '0)) begin
                if (wp1_hit) begin
                    rd = wdata1;
                end else if (wp0_hit) begin
                    rd = wdata0;
                end else begin
                    rd = regs[addr];
                end
            end
        end

        assign rdata[k*XLEN +: XLEN] = rd;
        // A same-cycle load writeback resolves the hazard, matching the bypassed data.
        assign rbusy[k] = ready & busy_q[addr] & ~wp1_hit;
    end

endmodule

// File: tb/tb_qar_regfile_mp.sv
// Directed self-checking bench for qar_regfile_mp at default parameters.
module tb_qar_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst_n;
    logic                ready;
    logic                we0;
    logic [AW-1:0]       waddr0;
    logic [XLEN-1:0]     wdata0;
    logic                we1;
    logic [AW-1:0]       waddr1;
    logic [XLEN-1:0]     wdata1;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;

    int n_checks = 0;
    int n_fail   = 0;

    qar_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ready     (ready),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard check
    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    function automatic logic [XLEN-1:0] rd(input int k);
        return rdata[k*XLEN +: XLEN];
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        raddr = '0;
        #2;
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_rbusy", 32'(rbusy), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1/2: clear sequence, writes and issues ignored while clearing
        for (int i = 1; i <= NREGS - 1; i++) begin
            tick();
            chk($sformatf("clr_ready_e%0d", i), 32'(ready), 32'(i == NREGS - 1));
            if (i == 2) begin
                we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
                we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h0000_0077;
                iss_valid = 1'b1; iss_addr = 5'd8;
                set_rd(5'd5, 5'd12);
                chk("clr_nobypass0", rd(0), 32'd0);
                chk("clr_nobypass1", rd(1), 32'd0);
                chk("clr_rbusy", 32'(rbusy), 32'd0);
            end else if (i == 3) begin
                idle();
            end
        end

        for (int a = 1; a < NREGS; a++) begin
            set_rd(AW'(a), AW'(NREGS - a));
            chk($sformatf("zero_x%0d", a), rd(0), 32'd0);
            chk($sformatf("zero_rev_x%0d", NREGS - a), rd(1), 32'd0);
        end
        set_rd(5'd8, 5'd12);
        chk("clr_iss_ignored", 32'(rbusy), 32'd0);

        // 3: dual write conflict, WP0-only write, x0 write
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        set_rd(5'd7, 5'd0);
        chk("dual_bypass", rd(0), 32'h22);
        tick();
        idle();
        set_rd(5'd7, 5'd0);
        chk("dual_store", rd(0), 32'h22);

        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h55;
        set_rd(5'd0, 5'd10);
        chk("wp0_bypass", rd(1), 32'h55);
        tick();
        idle();
        set_rd(5'd10, 5'd7);
        chk("wp0_store", rd(0), 32'h55);
        chk("wp0_other", rd(1), 32'h22);

        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFF;
        set_rd(5'd0, 5'd0);
        chk("x0_bypass", rd(0), 32'd0);
        tick();
        idle();
        set_rd(5'd0, 5'd0);
        chk("x0_store", rd(1), 32'd0);

        // 4: WP1 bypass on port 1, overriding a WP0 write to the same register
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h0000_0009;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hCAFE_0001;
        set_rd(5'd10, 5'd9);
        chk("wp1_bypass", rd(1), 32'hCAFE_0001);
        chk("bypass_other_port", rd(0), 32'h55);
        tick();
        idle();
        set_rd(5'd9, 5'd9);
        chk("wp1_store", rd(0), 32'hCAFE_0001);

        // 5: scoreboard
        iss_valid = 1'b1; iss_addr = 5'd3;
        set_rd(5'd3, 5'd4);
        chk("iss_not_yet", 32'(rbusy), 32'd0);
        tick();
        idle();
        set_rd(5'd3, 5'd4);
        chk("iss_busy", 32'(rbusy), 32'b01);
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h33;
        set_rd(5'd3, 5'd4);
        chk("wb_clears_comb", 32'(rbusy), 32'b00);
        chk("wb_bypass", rd(0), 32'h33);
        tick();
        idle();
        set_rd(5'd4, 5'd3);
        chk("wb_cleared", 32'(rbusy), 32'b00);

        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        iss_valid = 1'b1; iss_addr = 5'd3;
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h44;
        tick();
        idle();
        set_rd(5'd4, 5'd3);
        chk("set_wins", 32'(rbusy), 32'b10);
        chk("set_wins_data", rd(1), 32'h44);

        iss_valid = 1'b1; iss_addr = 5'd11;
        tick();
        idle();
        we0 = 1'b1; waddr0 = 5'd11; wdata0 = 32'hAB;
        tick();
        idle();
        set_rd(5'd11, 5'd3);
        chk("wp0_keeps_busy", 32'(rbusy), 32'b11);

        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h45;
        iss_valid = 1'b1; iss_addr = 5'd0;
        tick();
        idle();
        set_rd(5'd0, 5'd3);
        chk("x0_never_busy", 32'(rbusy), 32'b00);

        // 6: mid-operation reset
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h1234;
        tick();
        idle();
        iss_valid = 1'b1; iss_addr = 5'd6;
        tick();
        idle();
        set_rd(5'd4, 5'd6);
        chk("pre_rst_x4", rd(0), 32'h1234);
        chk("pre_rst_busy", 32'(rbusy), 32'b10);
        rst_n = 1'b0;
        #2;
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_rbusy", 32'(rbusy), 32'd0);
        chk("midrst_rdata", rd(0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= NREGS - 1; i++) begin
            tick();
            if (i == NREGS - 2 || i == NREGS - 1) begin
                chk($sformatf("reclr_ready_e%0d", i), 32'(ready), 32'(i == NREGS - 1));
            end
        end
        set_rd(5'd4, 5'd6);
        chk("reclr_x4", rd(0), 32'd0);
        chk("reclr_busy", 32'(rbusy), 32'd0);
        set_rd(5'd7, 5'd9);
        chk("reclr_x7", rd(0), 32'd0);
        chk("reclr_x9", rd(1), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
